// File: rtl/vga_capture.sv
// Capture side of a TinyVGA PMOD link: decodes sync and colour, recovers pixel
// coordinates, measures line/frame timing, signs each frame with a CRC and tracks lock.
module vga_capture #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_BACK          = 33,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [5:0]  pix_rgb,
    output logic [10:0] h_total,
    output logic [9:0]  v_total,
    output logic        frame_done,
    output logic [15:0] frame_crc,
    output logic        locked
);

    // Reset the sampling stages to "both syncs inactive" so no edge is seen at release.
    localparam logic [7:0]  IdleBus = SYNC_ACTIVE_LOW ? 8'h88 : 8'h00;
    localparam logic [11:0] HLo     = 12'(H_BACK);
    localparam logic [11:0] HHi     = 12'(H_BACK + H_ACTIVE);
    localparam logic [10:0] VLo     = 11'(V_BACK);
    localparam logic [10:0] VHi     = 11'(V_BACK + V_ACTIVE);
    localparam logic [10:0] HBack   = 11'(H_BACK);
    localparam logic [9:0]  VBack   = 10'(V_BACK);

    typedef enum logic [1:0] {StSearch, StSync1, StLocked} state_e;

    function automatic logic [15:0] crc_shift6(input logic [15:0] crc, input logic [5:0] data);
        logic [15:0] r;
        logic        fb;
        r = crc;
        for (int i = 5; i >= 0; i--) begin
            fb = r[15] ^ data[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    logic [7:0]  s1_q, s2_q;
    logic        hs1, hs2, vs1, vs2;
    logic        hs_start, hs_end, vs_start, vs_end;
    logic        hs_start_q, vs_start_q, vs_end_q, gap_q;
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        active;
    logic [5:0]  rgb_d;
    logic [15:0] crc_q, crc_base, crc_d;
    logic [10:0] hper_q, hper_d;
    logic [9:0]  lines_q, lines_d;
    logic [10:0] h_total_q, h_total_d;
    logic [9:0]  v_total_q, v_total_d;
    logic [10:0] ref_h_q;
    logic [9:0]  ref_v_q;
    logic        totals_match;
    state_e      state_q, state_d;
    logic        pix_valid_q, frame_done_q, locked_q;
    logic [9:0]  pix_x_q, pix_y_q;
    logic [5:0]  pix_rgb_q;
    logic [15:0] frame_crc_q;

    assign hs1 = s1_q[7] ^ SYNC_ACTIVE_LOW;
    assign hs2 = s2_q[7] ^ SYNC_ACTIVE_LOW;
    assign vs1 = s1_q[3] ^ SYNC_ACTIVE_LOW;
    assign vs2 = s2_q[3] ^ SYNC_ACTIVE_LOW;

    assign hs_start = hs1 & ~hs2;
    assign hs_end   = ~hs1 & hs2;
    assign vs_start = vs1 & ~vs2;
    assign vs_end   = ~vs1 & vs2;

    // Counters are aligned with s2: after an end edge, s2 holds the sample with count 0.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (hs_end) begin
            hcount_d = '0;
        end else if (hcount_q != 11'h7ff) begin
            hcount_d = hcount_q + 11'd1;
        end
        if (vs_end) begin
            vcount_d = '0;
        end else if (hs_end && vcount_q != 10'h3ff) begin
            vcount_d = vcount_q + 10'd1;
        end
    end

    assign active = ({1'b0, hcount_q} >= HLo) && ({1'b0, hcount_q} < HHi) &&
                    ({1'b0, vcount_q} >= VLo) && ({1'b0, vcount_q} < VHi);
    assign rgb_d  = {s2_q[0], s2_q[4], s2_q[1], s2_q[5], s2_q[2], s2_q[6]};

    // A pixel on the vsync-start sample still lands in the CRC before it is copied out.
    always_comb begin
        crc_base = vs_end_q ? 16'hffff : crc_q;
        crc_d    = active ? crc_shift6(crc_base, rgb_d) : crc_base;
    end

    always_comb begin
        hper_d    = hper_q;
        h_total_d = h_total_q;
        lines_d   = lines_q;
        v_total_d = v_total_q;
        if (hs_start_q) begin
            h_total_d = hper_q;
            hper_d    = 11'd1;
        end else if (hper_q != 11'h7ff) begin
            hper_d = hper_q + 11'd1;
        end
        if (hs_start_q && lines_q != 10'h3ff) begin
            lines_d = lines_q + 10'd1;
        end
        // A coincident hsync start belongs to the frame that is just closing.
        if (vs_start_q) begin
            v_total_d = lines_d;
            lines_d   = '0;
        end
    end

    assign totals_match = (h_total_d == ref_h_q) && (v_total_d == ref_v_q);

    always_comb begin
        state_d = state_q;
        if (gap_q) begin
            state_d = StSearch;
        end else if (vs_start_q) begin
            unique case (state_q)
                StSearch: state_d = StSync1;
                StSync1:  if (totals_match) state_d = StLocked;
                StLocked: if (!totals_match) state_d = StSync1;
                default:  state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= IdleBus;
            s2_q         <= IdleBus;
            hcount_q     <= 11'h7ff;
            vcount_q     <= 10'h3ff;
            hs_start_q   <= 1'b0;
            vs_start_q   <= 1'b0;
            vs_end_q     <= 1'b0;
            gap_q        <= 1'b0;
            crc_q        <= 16'hffff;
            hper_q       <= '0;
            lines_q      <= '0;
            h_total_q    <= '0;
            v_total_q    <= '0;
            ref_h_q      <= '0;
            ref_v_q      <= '0;
            state_q      <= StSearch;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_rgb_q    <= '0;
            frame_done_q <= 1'b0;
            frame_crc_q  <= 16'hffff;
            locked_q     <= 1'b0;
        end else begin
            s1_q         <= vga_in;
            s2_q         <= s1_q;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hs_start_q   <= hs_start;
            vs_start_q   <= vs_start;
            vs_end_q     <= vs_end;
            // Fires once, on the hsync that drives vcount into saturation.
            gap_q        <= hs_end & ~vs_end & (vcount_q == 10'd1022);
            crc_q        <= crc_d;
            hper_q       <= hper_d;
            lines_q      <= lines_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
            state_q      <= state_d;
            pix_valid_q  <= active;
            pix_x_q      <= active ? 10'(hcount_q - HBack) : 10'd0;
            pix_y_q      <= active ? (vcount_q - VBack) : 10'd0;
            pix_rgb_q    <= rgb_d;
            frame_done_q <= vs_start_q && (state_q != StSearch);
            locked_q     <= (state_d == StLocked);
            if (vs_start_q) begin
                frame_crc_q <= crc_d;
                ref_h_q     <= h_total_d;
                ref_v_q     <= v_total_d;
            end
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb    = pix_rgb_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;
    assign frame_done = frame_done_q;
    assign frame_crc  = frame_crc_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 16x8 raster (28 clocks/line, 15 lines/frame).
module tb_vga_capture;

    localparam int HA    = 16;
    localparam int VA    = 8;
    localparam int HB    = 4;
    localparam int VB    = 3;
    localparam int HS    = 4;               // hsync pulse width in clocks
    localparam int X0    = HS + HB;         // first active column within a line
    localparam int Y0    = 2 + VB;          // first active line (vsync spans two lines)
    localparam int LINES = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vga_in = 8'h88;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [5:0]  pix_rgb;
    logic [10:0] h_total;
    logic [9:0]  v_total;
    logic        frame_done;
    logic [15:0] frame_crc;
    logic        locked;

    int checks = 0;
    int errors = 0;

    // Per-run observations gathered by tick()
    int          tk, valid_cnt, first_tick, fd_cnt, fd_tick;
    logic [9:0]  first_x, first_y, last_x, last_y, fd_v;
    logic [5:0]  first_rgb;
    logic [10:0] fd_h;
    logic [15:0] fd_crc;
    logic        fd_lock;

    vga_capture #(
        .H_ACTIVE       (HA),
        .V_ACTIVE       (VA),
        .H_BACK         (HB),
        .V_BACK         (VB),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_in    (vga_in),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .h_total   (h_total),
        .v_total   (v_total),
        .frame_done(frame_done),
        .frame_crc (frame_crc),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] rgb_of(input logic [7:0] b);
        return {b[0], b[4], b[1], b[5], b[2], b[6]};
    endfunction

    function automatic logic [15:0] crc6(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [7:0] bus(input int l, input int c, input logic [7:0] col);
        logic       hs_act, vs_act;
        logic [7:0] b;
        hs_act = (c < HS);
        vs_act = (l == 0 && c >= HS) || (l == 1) || (l == 2 && c < HS);
        b = col & 8'h77;
        if (!hs_act) b = b | 8'h80;
        if (!vs_act) b = b | 8'h08;
        return b;
    endfunction

    task automatic clear_obs();
        tk = 0; valid_cnt = 0; first_tick = -1; fd_cnt = 0; fd_tick = -1;
        first_x = '0; first_y = '0; last_x = '0; last_y = '0; first_rgb = '0;
        fd_h = '0; fd_v = '0; fd_crc = '0; fd_lock = 1'b0;
    endtask

    // Drive one sample (entering just after an edge) and observe outputs after the next edge.
    task automatic tick(input logic [7:0] v);
        vga_in = v;
        @(posedge clk);
        #1;
        if (pix_valid) begin
            if (valid_cnt == 0) begin
                first_tick = tk; first_x = pix_x; first_y = pix_y; first_rgb = pix_rgb;
            end
            last_x = pix_x;
            last_y = pix_y;
            valid_cnt++;
        end
        if (frame_done) begin
            fd_cnt++; fd_tick = tk; fd_h = h_total; fd_v = v_total;
            fd_crc = frame_crc; fd_lock = locked;
        end
        tk++;
    endtask

    task automatic send_frame(input int hlen, input logic [7:0] col, input bit flip,
                              input int stop_at, output logic [15:0] crc_model);
        logic [15:0] crc;
        logic [7:0]  px;
        bit          act;
        crc       = 16'hffff;
        crc_model = 16'hffff;
        clear_obs();
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < hlen; c++) begin
                if (stop_at >= 0 && l * hlen + c == stop_at) return;
                act = (l >= Y0) && (l < Y0 + VA) && (c >= X0) && (c < X0 + HA);
                px  = 8'h00;
                if (act) begin
                    px  = (flip && (c - X0) == 10 && (l - Y0) == 5) ? 8'h11 : col;
                    crc = crc6(crc, rgb_of(px));
                end
                tick(bus(l, c, px));
            end
        end
        crc_model = crc;
    endtask

    task automatic send_gap(input int n);
        clear_obs();
        for (int l = 0; l < n; l++) begin
            for (int c = 0; c < 8; c++) begin
                tick((c < 2) ? 8'h08 : 8'h88);
            end
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_pix_valid"},  32'(pix_valid),  32'd0);
        check({p, "_pix_x"},      32'(pix_x),      32'd0);
        check({p, "_pix_y"},      32'(pix_y),      32'd0);
        check({p, "_pix_rgb"},    32'(pix_rgb),    32'd0);
        check({p, "_h_total"},    32'(h_total),    32'd0);
        check({p, "_v_total"},    32'(v_total),    32'd0);
        check({p, "_frame_done"}, 32'(frame_done), 32'd0);
        check({p, "_frame_crc"},  32'(frame_crc),  32'h0000ffff);
        check({p, "_locked"},     32'(locked),     32'd0);
    endtask

    initial begin
        logic [15:0] crc_m [0:15];
        logic [15:0] dummy, seen_f3, seen_f4;

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst0");
        rst_n = 1'b1;

        // F0: first vsync leaves SEARCH silently; pixel geometry and red decode
        send_frame(28, 8'h11, 1'b0, -1, crc_m[0]);
        check("f0_no_frame_done", 32'(fd_cnt),     32'd0);
        check("f0_valid_count",   32'(valid_cnt),  32'(HA * VA));
        check("f0_first_latency", 32'(first_tick), 32'(Y0 * 28 + X0 + 2));
        check("f0_first_x",       32'(first_x),    32'd0);
        check("f0_first_y",       32'(first_y),    32'd0);
        check("f0_rgb_red",       32'(first_rgb),  32'b110000);
        check("f0_last_x",        32'(last_x),     32'(HA - 1));
        check("f0_last_y",        32'(last_y),     32'(VA - 1));

        // F1: first frame_done, not yet locked; green decode
        send_frame(28, 8'h22, 1'b0, -1, crc_m[1]);
        check("f1_fd_count",  32'(fd_cnt),    32'd1);
        check("f1_fd_time",   32'(fd_tick),   32'd6);
        check("f1_h_total",   32'(fd_h),      32'd28);
        check("f1_v_total",   32'(fd_v),      32'd15);
        check("f1_locked",    32'(fd_lock),   32'd0);
        check("f1_crc",       32'(fd_crc),    32'(crc_m[0]));
        check("f1_rgb_green", 32'(first_rgb), 32'b001100);
        check("f1_valid",     32'(valid_cnt), 32'(HA * VA));

        // F2: locks at the second frame_done; blue decode
        send_frame(28, 8'h44, 1'b0, -1, crc_m[2]);
        check("f2_locked",   32'(fd_lock),   32'd1);
        check("f2_crc",      32'(fd_crc),    32'(crc_m[1]));
        check("f2_rgb_blue", 32'(first_rgb), 32'b000011);

        send_frame(28, 8'h44, 1'b0, -1, crc_m[3]);
        check("f3_crc", 32'(fd_crc), 32'(crc_m[2]));
        seen_f3 = fd_crc;

        // F4: one pixel flipped at (10,5)
        send_frame(28, 8'h44, 1'b1, -1, crc_m[4]);
        check("f4_crc",            32'(fd_crc), 32'(crc_m[3]));
        check("f4_crc_repeatable", 32'(fd_crc), 32'(seen_f3));
        seen_f4 = fd_crc;

        // F5: short lines (27 clocks)
        send_frame(27, 8'h44, 1'b0, -1, crc_m[5]);
        check("f5_crc",         32'(fd_crc),            32'(crc_m[4]));
        check("f5_crc_changed", 32'(fd_crc != seen_f4), 32'd1);
        check("f5_locked",      32'(fd_lock),           32'd1);
        check("f5_h_total",     32'(fd_h),              32'd28);

        send_frame(28, 8'h44, 1'b0, -1, crc_m[6]);
        check("f6_h_total", 32'(fd_h),    32'd27);
        check("f6_v_total", 32'(fd_v),    32'd15);
        check("f6_unlock",  32'(fd_lock), 32'd0);
        check("f6_crc",     32'(fd_crc),  32'(crc_m[5]));

        send_frame(28, 8'h44, 1'b0, -1, crc_m[7]);
        check("f7_locked",  32'(fd_lock), 32'd0);
        check("f7_h_total", 32'(fd_h),    32'd28);

        send_frame(28, 8'h44, 1'b0, -1, crc_m[8]);
        check("f8_relock", 32'(fd_lock), 32'd1);

        // Vsync gap: vcount saturates and forces SEARCH
        send_gap(1030);
        check("gap_no_frame_done", 32'(fd_cnt), 32'd0);
        check("gap_locked",        32'(locked), 32'd0);

        send_frame(28, 8'h44, 1'b0, -1, crc_m[9]);
        check("f9_search_silent", 32'(fd_cnt),    32'd0);
        check("f9_valid",         32'(valid_cnt), 32'(HA * VA));

        send_frame(28, 8'h44, 1'b0, -1, crc_m[10]);
        check("f10_fd_count", 32'(fd_cnt),  32'd1);
        check("f10_locked",   32'(fd_lock), 32'd0);

        send_frame(28, 8'h44, 1'b0, -1, crc_m[11]);
        check("f11_locked", 32'(fd_lock), 32'd1);

        // Mid-frame reset at line 7: outputs currently show sample (line 7, col 9)
        send_frame(28, 8'h44, 1'b0, 7 * 28 + 12, dummy);
        check("pre_rst_valid",  32'(pix_valid), 32'd1);
        check("pre_rst_x",      32'(pix_x),     32'd1);
        check("pre_rst_y",      32'(pix_y),     32'd2);
        check("pre_rst_locked", 32'(locked),    32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        vga_in = 8'h88;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_frame(28, 8'h44, 1'b0, -1, crc_m[12]);
        check("r0_search_silent", 32'(fd_cnt), 32'd0);
        check("r0_locked",        32'(locked), 32'd0);

        send_frame(28, 8'h44, 1'b0, -1, crc_m[13]);
        check("r1_fd_count", 32'(fd_cnt),  32'd1);
        check("r1_locked",   32'(fd_lock), 32'd0);
        check("r1_crc",      32'(fd_crc),  32'(crc_m[12]));

        send_frame(28, 8'h44, 1'b0, -1, crc_m[14]);
        check("r2_locked", 32'(fd_lock), 32'd1);
        check("r2_crc",    32'(fd_crc),  32'(crc_m[13]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
